// File: rtl/gate_self_test_pkg.sv
// Shared constants, state type and truth table for the basic-gates self-test.
package gate_self_test_pkg;

   localparam int NUM_GATES = 7;

   localparam int GATE_NOT  = 0;
   localparam int GATE_AND  = 1;
   localparam int GATE_OR   = 2;
   localparam int GATE_NAND = 3;
   localparam int GATE_NOR  = 4;
   localparam int GATE_XOR  = 5;
   localparam int GATE_XNOR = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_CHECK,
      ST_DONE
   } state_t;

   function automatic logic [NUM_GATES-1:0] gate_expected(input logic a, input logic b);
      logic [NUM_GATES-1:0] e;
      e            = '0;
      e[GATE_NOT]  = ~a;
      e[GATE_AND]  = a & b;
      e[GATE_OR]   = a | b;
      e[GATE_NAND] = ~(a & b);
      e[GATE_NOR]  = ~(a | b);
      e[GATE_XOR]  = a ^ b;
      e[GATE_XNOR] = ~(a ^ b);
      return e;
   endfunction

endpackage

// File: rtl/gate_self_test.sv
// Self-test harness: sweeps {a,b} through all four vectors and checks the gates block.
// Optional first-failure capture ports enabled by GATE_SELF_TEST_FIRST_FAIL_EN.
module gate_self_test
   import gate_self_test_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 a,
   output logic                 b,
   input  logic [NUM_GATES-1:0] gate_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [7:0]           err_count,
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
   output logic [1:0]           first_fail_vec,
   output logic [NUM_GATES-1:0] first_fail_bits,
`endif
   output logic [NUM_GATES-1:0] fail_mask
);

   state_t               state, state_n;
   logic [3:0]           settle_cnt, settle_cnt_n;
   logic [1:0]           vec, vec_n;
   logic [5:0]           pass_cnt, pass_cnt_n;
   logic                 a_n, b_n, busy_n, done_n, pass_n;
   logic [7:0]           err_count_n;
   logic [NUM_GATES-1:0] fail_mask_n;
   logic [NUM_GATES-1:0] mism;
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
   logic [1:0]           first_fail_vec_n;
   logic [NUM_GATES-1:0] first_fail_bits_n;
`endif

   // Compare against the registered drive values, which equal the current vector.
   assign mism = gate_out ^ gate_expected(a, b);

   always_comb begin
      state_n      = state;
      settle_cnt_n = settle_cnt;
      vec_n        = vec;
      pass_cnt_n   = pass_cnt;
      a_n          = a;
      b_n          = b;
      busy_n       = busy;
      done_n       = 1'b0;
      pass_n       = pass;
      err_count_n  = err_count;
      fail_mask_n  = fail_mask;
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
      first_fail_vec_n  = first_fail_vec;
      first_fail_bits_n = first_fail_bits;
`endif
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n      = ST_DRIVE;
               settle_cnt_n = '0;
               vec_n        = '0;
               pass_cnt_n   = '0;
               a_n          = 1'b0;
               b_n          = 1'b0;
               busy_n       = 1'b1;
               pass_n       = 1'b0;
               err_count_n  = '0;
               fail_mask_n  = '0;
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
               first_fail_vec_n  = '0;
               first_fail_bits_n = '0;
`endif
            end
         end
         ST_DRIVE: begin
            if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
               state_n      = ST_CHECK;
               settle_cnt_n = '0;
            end else begin
               settle_cnt_n = settle_cnt + 4'd1;
            end
         end
         ST_CHECK: begin
            if (mism != '0 && err_count != 8'hFF)
               err_count_n = err_count + 8'd1;
            fail_mask_n = fail_mask | mism;
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
            // A nonzero captured mismatch marks the first failure as already taken.
            if (mism != '0 && first_fail_bits == '0) begin
               first_fail_vec_n  = vec;
               first_fail_bits_n = mism;
            end
`endif
            if (vec == 2'd3 && pass_cnt == 6'(PASSES - 1)) begin
               state_n = ST_DONE;
               a_n     = 1'b0;
               b_n     = 1'b0;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               pass_n  = (err_count_n == 8'd0);
            end else begin
               state_n = ST_DRIVE;
               vec_n   = vec + 2'd1;
               if (vec == 2'd3)
                  pass_cnt_n = pass_cnt + 6'd1;
               {a_n, b_n} = vec + 2'd1;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         vec        <= '0;
         pass_cnt   <= '0;
         a          <= 1'b0;
         b          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_mask  <= '0;
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
         first_fail_vec  <= '0;
         first_fail_bits <= '0;
`endif
      end else begin
         state      <= state_n;
         settle_cnt <= settle_cnt_n;
         vec        <= vec_n;
         pass_cnt   <= pass_cnt_n;
         a          <= a_n;
         b          <= b_n;
         busy       <= busy_n;
         done       <= done_n;
         pass       <= pass_n;
         err_count  <= err_count_n;
         fail_mask  <= fail_mask_n;
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
         first_fail_vec  <= first_fail_vec_n;
         first_fail_bits <= first_fail_bits_n;
`endif
      end
   end

endmodule

// File: tb/tb_gate_self_test.sv
// Bench for gate_self_test: table-driven fault cases, hand sequences and randomized fault masks.
module tb_gate_self_test;
   import gate_self_test_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start3 = 1'b0;
   logic       a, b, busy, done, pass;
   logic [7:0] err_count;
   logic [6:0] fail_mask, gate_out;
   logic       a3, b3, busy3, done3, pass3;
   logic [7:0] err3;
   logic [6:0] mask3;
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
   logic [1:0] ffv, ffv3;
   logic [6:0] ffb, ffb3;
`endif

   // per-vector fault injection on the modelled gates block: (good & am) | om
   logic [6:0] am [4];
   logic [6:0] om [4];
   logic [1:0] ab_seq [1:40];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign gate_out = (gate_expected(a, b) & am[{a, b}]) | om[{a, b}];

   gate_self_test dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .gate_out(gate_out),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
      .first_fail_vec(ffv), .first_fail_bits(ffb),
`endif
      .fail_mask(fail_mask)
   );

   gate_self_test #(.SETTLE_CYCLES(2), .PASSES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .gate_out(7'd0),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
      .first_fail_vec(ffv3), .first_fail_bits(ffb3),
`endif
      .fail_mask(mask3)
   );

   typedef struct {
      string      name;
      logic [6:0] and_m;
      logic [6:0] or_m;
      int         exp_err;
      int         exp_mask;
      int         exp_pass;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic set_fault(input logic [6:0] and_m, input logic [6:0] or_m);
      for (int v = 0; v < 4; v++) begin
         am[v] = and_m;
         om[v] = or_m;
      end
   endtask

   // Pulse start at one edge (edge 0), then observe from cycle 1 until done+2.
   task automatic run_dut(output int done_cyc, output int busy_cnt, output int done_cnt);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      done_cyc = -1;
      busy_cnt = 0;
      done_cnt = 0;
      for (int c = 1; c <= 300; c++) begin
         if (c <= 40) ab_seq[c] = {a, b};
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc > 0 && c >= done_cyc + 2) break;
         @(negedge clk);
      end
   endtask

   // Reference: walk the sweep order directly and tally mismatches.
   task automatic ref_model(input int passes, output int e, output int m,
                            output int fv, output int fb);
      logic [1:0] vv;
      logic [6:0] exp7, mm;
      e = 0; m = 0; fv = 0; fb = 0;
      for (int p = 0; p < passes; p++)
         for (int v = 0; v < 4; v++) begin
            vv   = v[1:0];
            exp7 = gate_expected(vv[1], vv[0]);
            mm   = ((exp7 & am[v]) | om[v]) ^ exp7;
            if (mm != 0) begin
               if (e < 255) e++;
               if (fb == 0) begin fv = v; fb = int'(mm); end
            end
            m = m | int'(mm);
         end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [5];
      int dc, bc, nd, e, m, fv, fb, c;

      tbl[0] = '{"golden",       7'h7F, 7'h00, 0, 8'h00, 1};
      tbl[1] = '{"or_forced0",   7'h7B, 7'h00, 3, 8'h04, 0};
      tbl[2] = '{"all_zero",     7'h00, 7'h00, 4, 8'h7F, 0};
      tbl[3] = '{"xor_stuck1",   7'h7F, 7'h20, 2, 8'h20, 0};
      tbl[4] = '{"all_one",      7'h7F, 7'h7F, 4, 8'h7F, 0};

      set_fault(7'h7F, 7'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", int'({a, b, busy, done, pass, err_count, fail_mask}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // golden run: timing and drive sequence
      run_dut(dc, bc, nd);
      chk("golden_done_cycle", dc, 13);
      chk("golden_busy_cycles", bc, 12);
      chk("golden_done_pulses", nd, 1);
      for (int k = 1; k <= 12; k++)
         chk($sformatf("golden_ab_cycle%0d", k), int'(ab_seq[k]), (k - 1) / 3);
      chk("golden_ab_done", int'(ab_seq[13]), 0);
      chk("golden_pass", int'(pass), 1);

      foreach (tbl[i]) begin
         set_fault(tbl[i].and_m, tbl[i].or_m);
         run_dut(dc, bc, nd);
         chk({tbl[i].name, "_done_cycle"}, dc, 13);
         chk({tbl[i].name, "_err"}, int'(err_count), tbl[i].exp_err);
         chk({tbl[i].name, "_mask"}, int'(fail_mask), tbl[i].exp_mask);
         chk({tbl[i].name, "_pass"}, int'(pass), tbl[i].exp_pass);
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
         if (i == 3) begin
            chk("xor_stuck1_ffvec", int'(ffv), 0);
            chk("xor_stuck1_ffbits", int'(ffb), 8'h20);
         end
         if (i == 0) chk("golden_ffbits", int'(ffb), 0);
`endif
      end

      // three passes, gate_out tied low
      @(negedge clk) start3 = 1'b1;
      @(posedge clk);
      @(negedge clk) start3 = 1'b0;
      dc = -1;
      for (int k = 1; k <= 100; k++) begin
         if (done3) begin dc = k; break; end
         @(negedge clk);
      end
      chk("p3_done_cycle", dc, 37);
      @(negedge clk);
      chk("p3_err", int'(err3), 12);
      chk("p3_mask", int'(mask3), 8'h7F);
      chk("p3_pass", int'(pass3), 0);

      // start pulses at cycle 5 and in DONE are ignored
      set_fault(7'h00, 7'h00);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      nd = 0; dc = -1; bc = 0;
      for (int k = 1; k <= 30; k++) begin
         start = (k == 5 || k == 13);
         if (done) begin nd++; if (dc < 0) dc = k; end
         if (k > 13 && busy) bc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("ign_done_pulses", nd, 1);
      chk("ign_done_cycle", dc, 13);
      chk("ign_busy_after_done", bc, 0);
      chk("ign_err", int'(err_count), 4);
      set_fault(7'h7F, 7'h00);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      chk("restart_clear_err", int'(err_count), 0);
      chk("restart_clear_mask", int'(fail_mask), 0);
      chk("restart_busy", int'(busy), 1);
      dc = -1;
      for (int k = 1; k <= 50; k++) begin
         if (done) begin dc = k; break; end
         @(negedge clk);
      end
      chk("restart_done_cycle", dc, 13);

      // async reset mid-run
      set_fault(7'h00, 7'h00);
      repeat (2) @(negedge clk);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("midreset_outputs", int'({a, b, busy, done, pass, err_count, fail_mask}), 0);
      @(negedge clk) rst_n = 1'b1;
      nd = 0;
      for (int k = 0; k < 20; k++) begin
         if (done || busy) nd++;
         @(negedge clk);
      end
      chk("midreset_idle", nd, 0);
      set_fault(7'h7F, 7'h00);
      run_dut(dc, bc, nd);
      chk("postreset_done_cycle", dc, 13);
      chk("postreset_pass", int'(pass), 1);

      // randomized per-vector faults against the reference model
      for (int it = 0; it < 20; it++) begin
         for (int v = 0; v < 4; v++) begin
            am[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h7F;
            om[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
         end
         ref_model(1, e, m, fv, fb);
         run_dut(dc, bc, nd);
         c = it;
         chk($sformatf("rand%0d_err", c), int'(err_count), e);
         chk($sformatf("rand%0d_mask", c), int'(fail_mask), m);
         chk($sformatf("rand%0d_pass", c), int'(pass), (e == 0) ? 1 : 0);
`ifdef GATE_SELF_TEST_FIRST_FAIL_EN
         chk($sformatf("rand%0d_ffvec", c), int'(ffv), fv);
         chk($sformatf("rand%0d_ffbits", c), int'(ffb), fb);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_self_test.md
# gate_self_test

Sequential self-test harness for the two-input basic-gates block. It drives the gates block's `a`/`b` inputs through every input combination and samples its 7-bit result vector. Each sample is compared against a built-in truth table, and the block reports pass/fail, a mismatch count and a per-gate failure mask. It is both the upstream stimulus stage and the downstream checker of the gates block, used for bring-up and built-in self-test.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles the DUT inputs are held before sampling; legal range 1..15.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range 1..63.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a run; accepted only in IDLE.
- `a` out 1: drives the gates block input `a`.
- `b` out 1: drives the gates block input `b`.
- `gate_out` in 7: result from the gates block.
  - Bit 0 = NOT a, 1 = AND, 2 = OR, 3 = NAND, 4 = NOR, 5 = XOR, 6 = XNOR.
- `busy` out 1: high from the cycle after start is accepted until the DONE cycle exclusive.
- `done` out 1: single-cycle pulse at end of run.
- `pass` out 1: high when the last run had zero mismatches.
- `err_count` out 8: number of mismatching vector samples in the last run; saturates at 255.
- `fail_mask` out 7: sticky OR of mismatching bit positions over the run.

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE.
  - IDLE: `start`=1 moves to DRIVE. On acceptance, clear `err_count`, `fail_mask`, `pass`, the vector index and the pass counter.
  - DRIVE: `{a,b}` = current vector. Stay SETTLE_CYCLES cycles, counted by the settle counter, then go to CHECK.
  - CHECK, one cycle: compare `gate_out` with expected(a,b).
    - mismatch = `gate_out` ^ expected.
    - If mismatch != 0, increment `err_count` (saturating). Always OR mismatch into `fail_mask`.
    - If more vectors remain, advance and go to DRIVE. Otherwise go to DONE.
  - DONE, one cycle: `done`=1. Register `pass` = (`err_count`==0 including this final update). Go to IDLE.
- Vector order within a sweep: `{a,b}` = 00, 01, 10, 11. The index wraps 11 -> 00 and increments the pass counter. The run ends after the CHECK of vector 11 on pass PASSES.
- Expected vectors, written bits 6..0: 00 -> 0x59, 01 -> 0x2D, 10 -> 0x2C, 11 -> 0x46.
- `a`,`b` are 0 in IDLE and DONE.
- `start` is ignored while busy and in DONE; there is no queueing.
- `err_count`, `fail_mask` and `pass` hold their values after DONE until the next accepted start.

## Timing
- All outputs are registered.
- Reset value of every output is 0: `a`, `b`, `busy`, `done`, `pass`, `err_count`, `fail_mask`.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0; no `done` pulse.
- `start` sampled high at edge 0 gives:
  - `busy`=1 and first vector on `a`/`b` after edge 0.
  - CHECK samples `gate_out` in the cycle after the last DRIVE cycle. The gates block is combinational, so the result is stable.
  - `done`=1 in the cycle after edge 4·PASSES·(SETTLE_CYCLES+1).
  - Defaults: `done` in cycle 13; `busy` high cycles 1..12.
- `gate_out` is ignored outside CHECK cycles.

## Configuration
- `GATE_SELF_TEST_FIRST_FAIL_EN`
  - Defined: adds outputs `first_fail_vec` (2 bits, `{a,b}`) and `first_fail_bits` (7 bits, mismatch vector).
    - Both are captured at the first mismatching CHECK of the run and held until the next accepted start.
    - Both are cleared on start and reset, and stay 0 if the run passes.
  - Undefined: the ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package `gate_self_test_pkg`:
  - `NUM_GATES` = 7.
  - Gate bit-index constants `GATE_NOT` .. `GATE_XNOR`.
  - State enum type.
  - Function `gate_expected(a,b)` returning the 7-bit expected vector; the bench reuses it as its reference model.
- No sub-module. FSM, settle counter, vector/pass counters and the checker live in one module. The gates block is instantiated beside it by the integrator.

## Test plan
- Golden gates block connected, defaults, start at edge 0:
  - `{a,b}` sequence 00 (cycles 1-3), 01, 10, 11.
  - `done` in cycle 13; `pass`=1, `err_count`=0, `fail_mask`=0.
- `gate_out[2]` forced 0:
  - `err_count`=3 (vectors 01, 10, 11), `fail_mask`=0x04, `pass`=0.
- PASSES=3, `gate_out` tied to 0:
  - `err_count`=12, `fail_mask`=0x7F.
  - `done` in cycle 1+36=37.
- `start` pulsed in cycles 5 and 13 (DONE) of a default run:
  - Both ignored; a single `done` pulse.
  - A later start clears `err_count`/`fail_mask` before the new run.
- `rst_n` low in cycle 7 of a run:
  - All outputs 0 asynchronously, IDLE, no `done`.
  - A new start after release completes normally.
- Macro defined, `gate_out[5]` stuck 1:
  - `first_fail_vec`=00, `first_fail_bits`=0x20, `err_count`=2.
